// File: rtl/fire_scheduler.sv
// Picks at most one enabled transition per cycle and presents its index on `fire`.
// Round-robin or LFSR-seeded selection, single-step support, firing budget, deadlock detection.
module fire_scheduler #(
  parameter int          N         = 8,
  parameter int          W         = $clog2(N + 1),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          step_mode,
  input  logic          step,
  input  logic [31:0]   budget,
  input  logic [N-1:0]  enabled,
  output logic [W-1:0]  fire,
  output logic          fire_valid,
  output logic [31:0]   fire_count,
  output logic [1:0]    state,
  output logic          deadlock
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  logic [SW-1:0] ptr;
  logic [SW-1:0] rnd;
  logic [SW-1:0] scan_start;
  logic [15:0]   lfsr;
  logic [31:0]   budget_q;
  logic [W-1:0]  pick;
  logic          any_en;
  logic          start_ok;
  logic          hit_budget;
  logic          lfsr_fb;

  assign rnd      = lfsr[SW-1:0];
  assign any_en   = |enabled;
  assign start_ok = start && (state != ST_RUN);
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    scan_start = ptr;
    if (mode) begin
      scan_start = (int'(rnd) < N) ? rnd : SW'(int'(rnd) - N);
    end
  end

  // Walk the offsets downward so the smallest offset from scan_start is the final winner.
  always_comb begin
    pick = W'(N);
    for (int d = N - 1; d >= 0; d--) begin
      if (enabled[SW'((int'(scan_start) + d) % N)]) begin
        pick = W'((int'(scan_start) + d) % N);
      end
    end
  end

  assign fire_valid = (state == ST_RUN) && any_en && (!step_mode || step);
  assign fire       = fire_valid ? pick : W'(N);
  assign deadlock   = (state == ST_DEAD);
  assign hit_budget = fire_valid && (budget_q != 32'd0) &&
                      (({1'b0, fire_count} + 33'd1) == {1'b0, budget_q});

  // NOTE: all registered state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      fire_count <= 32'd0;
      ptr        <= '0;
      lfsr       <= LFSR_SEED;
      budget_q   <= 32'd0;
    end else begin
      if (stop) begin
        state <= ST_IDLE;
      end else if (start_ok) begin
        state <= ST_RUN;
      end else if (state == ST_RUN) begin
        if (hit_budget)   state <= ST_DONE;
        else if (!any_en) state <= ST_DEAD;
      end

      if (start_ok && !stop) begin
        fire_count <= 32'd0;
        budget_q   <= budget;
        ptr        <= '0;
        lfsr       <= LFSR_SEED;
      end else begin
        if (fire_valid) begin
          ptr <= SW'((int'(pick) + 1) % N);
          if (fire_count != 32'hFFFF_FFFF) fire_count <= fire_count + 32'd1;
        end
        if (state == ST_RUN) lfsr <= {lfsr_fb, lfsr[15:1]};
      end
    end
  end

endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler: a spec-level reference model checked every cycle,
// plus directed sequences with hand-computed firing orders.
module tb_fire_scheduler;

  localparam int N = 8;
  localparam int W = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk;
  logic          reset;
  logic          start, stop, mode, step_mode, step;
  logic [31:0]   budget;
  logic [N-1:0]  enabled;
  logic [W-1:0]  fire;
  logic          fire_valid;
  logic [31:0]   fire_count;
  logic [1:0]    state;
  logic          deadlock;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;
  int fires[$];
  int first_run[$];

  // Reference model state
  int          m_state;
  int          m_ptr;
  logic [15:0] m_lfsr;
  logic [31:0] m_count;
  logic [31:0] m_budget;

  fire_scheduler #(.N(N), .W(W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .step_mode(step_mode), .step(step), .budget(budget), .enabled(enabled),
    .fire(fire), .fire_valid(fire_valid), .fire_count(fire_count),
    .state(state), .deadlock(deadlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  // The transition that must fire now, or N if none.
  function automatic int exp_fire();
    int s;
    int r;
    if (m_state != 1 || enabled == '0 || (step_mode && !step)) return N;
    if (mode) begin
      r = int'(m_lfsr) % (1 << $clog2(N));
      s = (r < N) ? r : r - N;
    end else begin
      s = m_ptr;
    end
    for (int d = 0; d < N; d++) begin
      if (enabled[(s + d) % N]) return (s + d) % N;
    end
    return N;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state  <= 0;
      m_ptr    <= 0;
      m_lfsr   <= SEED;
      m_count  <= 0;
      m_budget <= 0;
    end else begin
      if (stop) m_state <= 0;
      else if (start && m_state != 1) m_state <= 1;
      else if (m_state == 1 && exp_fire() < N && m_budget != 0 &&
               longint'(m_count) + 1 == longint'(m_budget)) m_state <= 2;
      else if (m_state == 1 && enabled == '0) m_state <= 3;

      if (!stop && start && m_state != 1) begin
        m_count  <= 0;
        m_budget <= budget;
        m_ptr    <= 0;
        m_lfsr   <= SEED;
      end else begin
        if (exp_fire() < N) begin
          m_ptr <= (exp_fire() + 1) % N;
          if (m_count != 32'hFFFF_FFFF) m_count <= m_count + 1;
        end
        if (m_state == 1) m_lfsr <= lfsr_next(m_lfsr);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (reset && cmp_en) begin
      check("fire", 32'(fire), 32'(exp_fire()));
      check("fire_valid", 32'(fire_valid), 32'(exp_fire() < N));
      check("fire_count", fire_count, m_count);
      check("state", 32'(state), 32'(m_state));
      check("deadlock", 32'(deadlock), 32'(m_state == 3));
      if (fire_valid) fires.push_back(int'(fire));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    check({name, "_len"}, 32'(fires.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < fires.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(fires[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    reset = 1'b0; start = 0; stop = 0; mode = 0; step_mode = 0; step = 0;
    budget = 0; enabled = '0;
    #3;
    check("rst_fire", 32'(fire), 32'd8);
    check("rst_fire_valid", 32'(fire_valid), 32'd0);
    check("rst_fire_count", fire_count, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_deadlock", 32'(deadlock), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    cmp_en = 1;

    // Round-robin, everything enabled, unlimited budget
    enabled = 8'hFF;
    fires.delete();
    do_start();
    repeat (10) tick();
    check_seq("rr", '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});
    check("rr_count", fire_count, 32'd10);
    do_stop();
    check("rr_stop_state", 32'(state), 32'd0);

    // Budget of three with two enabled transitions
    enabled = 8'b0010_0100;
    budget  = 32'd3;
    fires.delete();
    do_start();
    repeat (5) tick();
    check_seq("budget", '{2, 5, 2});
    check("budget_state", 32'(state), 32'd2);
    check("budget_fire", 32'(fire), 32'd8);
    check("budget_count", fire_count, 32'd3);

    // stop beats start in DONE
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stop_prio_state", 32'(state), 32'd0);

    // Deadlock when nothing is enabled in cycle 4
    enabled = 8'hFF;
    budget  = 32'd0;
    do_start();
    repeat (3) tick();
    enabled = '0;
    #1;
    check("dead_cycle_fire", 32'(fire), 32'd8);
    tick();
    check("dead_state", 32'(state), 32'd3);
    check("dead_flag", 32'(deadlock), 32'd1);
    enabled = 8'hFF;
    do_start();
    check("restart_state", 32'(state), 32'd1);
    check("restart_count", fire_count, 32'd0);
    do_stop();

    // Single-step: step high in run cycles 2 and 5 only
    step_mode = 1'b1;
    fires.delete();
    do_start();
    for (int c = 1; c <= 7; c++) begin
      step = (c == 2 || c == 5);
      tick();
    end
    step = 1'b0;
    check_seq("step", '{0, 1});
    check("step_count", fire_count, 32'd2);
    do_stop();
    step_mode = 1'b0;

    // Random mode: sequence follows the LFSR and repeats after a fresh start
    mode = 1'b1;
    fires.delete();
    do_start();
    repeat (12) tick();
    first_run = fires;
    check_seq("rnd_head", '{1, 0, 0, 4, 6, first_run[5], first_run[6], first_run[7],
                            first_run[8], first_run[9], first_run[10], first_run[11]});
    do_stop();
    fires.delete();
    do_start();
    repeat (12) tick();
    check_seq("rnd_repeat", first_run);
    do_stop();
    mode = 1'b0;

    // Asynchronous reset in the middle of a run
    do_start();
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_fire", 32'(fire), 32'd8);
    check("async_valid", 32'(fire_valid), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_count", fire_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("post_reset_state", 32'(state), 32'd0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
